// File: rtl/if_fetch.sv
// Instruction fetch: assembles little-endian 32-bit words from a byte-wide memory port.
// Define IF_ICACHE_EN to add a direct-mapped one-word-per-line instruction cache.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_sign,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  input  logic        mem_busy_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    S_ISSUE0 = 3'd0,
    S_ISSUE1 = 3'd1,
    S_ISSUE2 = 3'd2,
    S_ISSUE3 = 3'd3,
    S_LAST   = 3'd4,
    S_HOLD   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        pend_q, pend_d;
  logic [7:0]  byte_q [3];
  logic [2:0]  cap_en;
  logic        issue;
  logic [1:0]  off;
  logic        fill;
  logic        cache_hit;
  logic [31:0] cache_rdata;

  logic unused_stall;
  assign unused_stall = ^{stall_sign[5:2], stall_sign[0]};

`ifdef IF_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             cache_data_mem [ICACHE_LINES];
  logic [TAG_W-1:0]        cache_tag_mem  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cache_valid_q;
  logic [IDX_W-1:0]        cache_idx;
  logic [TAG_W-1:0]        cache_tag;
  logic                    unused_pc_lsb;

  assign cache_idx     = fetch_pc_q[IDX_W+1:2];
  assign cache_tag     = fetch_pc_q[31:IDX_W+2];
  assign unused_pc_lsb = ^fetch_pc_q[1:0];
  assign cache_hit     = cache_valid_q[cache_idx] && (cache_tag_mem[cache_idx] == cache_tag);
  assign cache_rdata   = cache_data_mem[cache_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= '0;
    end else if (fill) begin
      cache_valid_q[cache_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      cache_data_mem[cache_idx] <= inst_d;
      cache_tag_mem[cache_idx]  <= cache_tag;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = fill ^ ICACHE_LINES[0];
  assign cache_hit   = 1'b0;
  assign cache_rdata = '0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    issue      = 1'b0;
    off        = 2'd0;
    cap_en     = '0;
    fill       = 1'b0;

    case (state_q)
      S_ISSUE0: begin
        if (cache_hit) begin
          pc_d    = fetch_pc_q;
          inst_d  = cache_rdata;
          state_d = S_HOLD;
        end else if (!mem_busy_i) begin
          issue   = 1'b1;
          state_d = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        cap_en[0] = pend_q;
        off       = 2'd1;
        if (!mem_busy_i) begin
          issue   = 1'b1;
          state_d = S_ISSUE2;
        end
      end
      S_ISSUE2: begin
        cap_en[1] = pend_q;
        off       = 2'd2;
        if (!mem_busy_i) begin
          issue   = 1'b1;
          state_d = S_ISSUE3;
        end
      end
      S_ISSUE3: begin
        cap_en[2] = pend_q;
        off       = 2'd3;
        if (!mem_busy_i) begin
          issue   = 1'b1;
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        // byte3 arrives now; it goes straight into the word without its own register
        inst_d  = {mem_data_i, byte_q[2], byte_q[1], byte_q[0]};
        pc_d    = fetch_pc_q;
        fill    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!stall_sign[1]) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_ISSUE0;
        end
      end
      default: state_d = S_ISSUE0;
    endcase

    // Redirect wins over everything; the outstanding byte is dropped via pend_d.
    if (branch_enable_i) begin
      state_d    = S_ISSUE0;
      fetch_pc_d = branch_addr_i;
      pc_d       = pc_q;
      inst_d     = inst_q;
      fill       = 1'b0;
    end
  end

  assign pend_d = issue & ~branch_enable_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ISSUE0;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inst_q     <= '0;
      pend_q     <= 1'b0;
      for (int i = 0; i < 3; i++) byte_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pend_q     <= pend_d;
      for (int i = 0; i < 3; i++) begin
        if (cap_en[i]) byte_q[i] <= mem_data_i;
      end
    end
  end

  assign mem_req_o    = issue & ~rst;
  assign mem_addr_o   = mem_req_o ? (fetch_pc_q + {30'd0, off}) : 32'd0;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = (state_q == S_HOLD) & ~branch_enable_i;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector tables plus a randomized run against a
// fetch-progress model (issues counted per word, byte memory, optional cache map).
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_sign;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        mem_busy_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_sign      (stall_sign),
    .branch_enable_i (branch_enable_i),
    .branch_addr_i   (branch_addr_i),
    .mem_busy_i      (mem_busy_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_i      (mem_data_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  typedef struct {
    bit          rst, busy, stall, br;
    logic [31:0] baddr;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    bit          chk;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  logic [7:0]  arr [1024];
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl [$];
  vec_t        ctbl [$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return arr[a[9:0]];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic vec_t v(input bit r, b, s, br, input logic [31:0] ba,
                             input bit er, input logic [31:0] ea, input bit ev,
                             input bit chk, input logic [31:0] ep, ei);
    vec_t x;
    x.rst = r; x.busy = b; x.stall = s; x.br = br; x.baddr = ba;
    x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.chk = chk; x.e_pc = ep; x.e_inst = ei;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, b, s, br, input logic [31:0] ba);
    logic [5:0] st;
    st = 6'($urandom);
    st[1] = s;
    rst = r; mem_busy_i = b; stall_sign = st; branch_enable_i = br; branch_addr_i = ba;
  endtask

  // Memory responder: a byte is returned only the cycle after an issue, garbage otherwise.
  task automatic finish_cycle();
    logic        req;
    logic [31:0] addr;
    req  = mem_req_o;
    addr = mem_addr_o;
    @(posedge clk);
    #1;
    mem_data_i = req ? mem_byte(addr) : 8'($urandom);
  endtask

  task automatic run_table(input string tag, input vec_t t[$]);
    foreach (t[i]) begin
      drive(t[i].rst, t[i].busy, t[i].stall, t[i].br, t[i].baddr);
      @(negedge clk);
      $display("%s[%0d] rst=%0b busy=%0b stall=%0b br=%0b req=%0b addr=%h valid=%0b pc=%h inst=%h",
               tag, i, t[i].rst, t[i].busy, t[i].stall, t[i].br, mem_req_o, mem_addr_o,
               inst_valid_o, pc_o, inst_o);
      check($sformatf("%s[%0d].req", tag, i), {31'd0, mem_req_o}, {31'd0, t[i].e_req});
      check($sformatf("%s[%0d].addr", tag, i), mem_addr_o, t[i].e_addr);
      check($sformatf("%s[%0d].valid", tag, i), {31'd0, inst_valid_o}, {31'd0, t[i].e_valid});
      if (t[i].chk) begin
        check($sformatf("%s[%0d].pc", tag, i), pc_o, t[i].e_pc);
        check($sformatf("%s[%0d].inst", tag, i), inst_o, t[i].e_inst);
      end
      finish_cycle();
    end
  endtask

  task automatic run_random(input int cycles);
    logic [31:0] m_pc, m_inst, ba, e_addr;
    int          m_n;
    bit          m_since, b, s, br, hit, e_req, hold;
    logic [31:0] c_pc [64];
    logic [31:0] c_inst [64];
    bit          c_v [64];
    int          handoffs;
    for (int i = 0; i < 64; i++) c_v[i] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      finish_cycle();
    end
    m_pc = 32'h0; m_n = 0; m_since = 1'b0; m_inst = 32'h0; handoffs = 0;
    for (int c = 0; c < cycles; c++) begin
      b  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 19) == 0);
      ba = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 31)) << 2);
      drive(1'b0, b, s, br, ba);
      @(negedge clk);
      hit = 1'b0;
`ifdef IF_ICACHE_EN
      hit = (m_n == 0) && c_v[m_pc[7:2]] && (c_pc[m_pc[7:2]][31:2] == m_pc[31:2]);
`endif
      e_req  = (m_n < 4) && !b && !hit;
      e_addr = e_req ? m_pc + 32'(m_n) : 32'd0;
      hold   = (m_n == 4) && m_since;
      check($sformatf("rnd%0d.req", c), {31'd0, mem_req_o}, {31'd0, e_req});
      check($sformatf("rnd%0d.addr", c), mem_addr_o, e_addr);
      check($sformatf("rnd%0d.valid", c), {31'd0, inst_valid_o}, {31'd0, hold && !br});
      if (hold) begin
        check($sformatf("rnd%0d.pc", c), pc_o, m_pc);
        check($sformatf("rnd%0d.inst", c), inst_o, m_inst);
        if (!br && !s) begin
          handoffs++;
          $display("handoff %0d cycle=%0d pc=%h inst=%h", handoffs, c, pc_o, inst_o);
        end
      end
      if (br) begin
        m_pc = ba; m_n = 0; m_since = 1'b0;
      end else if (hit) begin
        m_n = 4; m_since = 1'b1; m_inst = c_inst[m_pc[7:2]];
      end else if (m_n < 4) begin
        if (e_req) m_n++;
      end else if (!m_since) begin
        m_since = 1'b1;
        m_inst  = mem_word(m_pc);
        c_v[m_pc[7:2]] = 1'b1; c_pc[m_pc[7:2]] = m_pc; c_inst[m_pc[7:2]] = m_inst;
      end else if (!s) begin
        m_pc = m_pc + 32'd4; m_n = 0; m_since = 1'b0;
      end
      finish_cycle();
    end
  endtask

  initial begin
    mem_data_i = 8'h00;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 1024; i++) arr[i] = 8'(i * 7 + 3);
    arr[0] = 8'h13;   arr[1] = 8'h05;   arr[2] = 8'h10;   arr[3] = 8'h00;
    arr[4] = 8'h93;   arr[5] = 8'h05;   arr[6] = 8'h20;   arr[7] = 8'h00;
    arr[256] = 8'hEF; arr[257] = 8'h00; arr[258] = 8'h00; arr[259] = 8'h01;
    arr[515] = 8'h11; arr[516] = 8'h22; arr[517] = 8'h33; arr[518] = 8'h44;
    arr[1022] = 8'hAB; arr[1023] = 8'hCD;

    //               rst b s br baddr         req addr          val chk pc            inst
    tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h1,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h2,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h3,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h4,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h5,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h6,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h7,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h4,        32'h00200593));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h9,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 1, 32'h100,      1, 32'hA,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h100,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h101,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h102,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h103,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h100,      32'h010000EF));
    tbl.push_back(v(0, 0, 0, 1, 32'h203,      1, 32'h104,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h203,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h204,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h205,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h206,      0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,        0, 1, 32'h203,      32'h44332211));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFE, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h1,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hFFFFFFFE, 32'h0513CDAB));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h2,        0, 0, 32'h0,        32'h0));
    run_table("vec", tbl);

`ifdef IF_ICACHE_EN
    ctbl.push_back(v(1, 0, 0, 0, 32'h0,       0, 32'h0,        0, 1, 32'h0,        32'h0));
    ctbl.push_back(v(1, 0, 0, 0, 32'h0,       0, 32'h0,        0, 1, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       1, 32'h0,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       1, 32'h1,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       1, 32'h2,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       1, 32'h3,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    ctbl.push_back(v(0, 0, 0, 1, 32'h0,       1, 32'h4,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0,        32'h0));
    ctbl.push_back(v(0, 0, 0, 0, 32'h0,       0, 32'h0,        1, 1, 32'h0,        32'h00100513));
    run_table("cache", ctbl);
`endif

    run_random(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
